// File: rtl/cb_pkg.sv
// Shared helpers for the connection-block family (cbx/cby): sizing of the
// per-mux select fields, the configuration chain and its bit counter.
package cb_pkg;

    function automatic int cb_clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int cb_sel_w(input int mux_size);
        return cb_clog2(mux_size);
    endfunction

    function automatic int cb_cfg_bits(input int num_ipin, input int mux_size);
        return num_ipin * cb_sel_w(mux_size);
    endfunction

    // One extra bit so an overlong load saturates above CFG_BITS instead of wrapping onto it.
    function automatic int cb_cnt_w(input int cfg_bits);
        return cb_clog2(cfg_bits) + 1;
    endfunction

endpackage

// File: rtl/cb_cfg_chain.sv
// Serial configuration chain with a length-checked commit into a shadow
// register, so the routing muxes only ever see a complete configuration.
module cb_cfg_chain
    import cb_pkg::*;
#(
    parameter int NUM_IPIN = 2,
    parameter int MUX_SIZE = 10,
    parameter int SEL_W    = 4,
    parameter int CFG_BITS = 8
) (
    input  logic                prog_clk,
    input  logic                prog_reset_n,
    input  logic                ccff_en,
    input  logic                ccff_head,
    input  logic                cfg_commit,
    output logic                ccff_tail,
    output logic [CFG_BITS-1:0] active,
    output logic                cfg_valid,
    output logic                cfg_err
);

    localparam int                CNT_W      = cb_cnt_w(CFG_BITS);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(CFG_BITS);
    localparam logic [SEL_W:0]    SEL_LIMIT  = (SEL_W+1)'(MUX_SIZE);

    logic [CFG_BITS-1:0] chain;
    logic [CNT_W-1:0]    cnt;
    logic                sel_oob;

    always_comb begin
        sel_oob = 1'b0;
        for (int i = 0; i < NUM_IPIN; i++) begin
            if ({1'b0, chain[i*SEL_W +: SEL_W]} >= SEL_LIMIT) begin
                sel_oob = 1'b1;
            end
        end
    end

    // Shifting takes priority; a commit only acts on a quiet chain.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            chain     <= '0;
            cnt       <= '0;
            active    <= '0;
            cfg_valid <= 1'b0;
            cfg_err   <= 1'b0;
        end else if (ccff_en) begin
            chain <= {chain[CFG_BITS-2:0], ccff_head};
            if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end else if (cfg_commit) begin
            cnt <= '0;
            if (cnt == CNT_LOAD) begin
                active    <= chain;
                cfg_valid <= 1'b1;
                if (sel_oob) begin
                    cfg_err <= 1'b1;
                end
            end else begin
                cfg_err <= 1'b1;
            end
        end
    end

    assign ccff_tail = chain[CFG_BITS-1];

endmodule

// File: rtl/cby_param_cfg.sv
// Y-direction connection block: vertical tracks pass straight through and
// NUM_IPIN routing muxes pick grid input pins from a window of tracks.
module cby_param_cfg
    import cb_pkg::*;
#(
    parameter int CHAN_WIDTH  = 11,
    parameter int NUM_IPIN    = 2,
    parameter int MUX_SIZE    = 10,
    parameter int IPIN_STRIDE = 1
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset_n,
    input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
    input  logic [CHAN_WIDTH-1:0] chany_top_in,
    output logic [CHAN_WIDTH-1:0] chany_bottom_out,
    output logic [CHAN_WIDTH-1:0] chany_top_out,
    input  logic                  ccff_en,
    input  logic                  ccff_head,
    output logic                  ccff_tail,
    input  logic                  cfg_commit,
    output logic [NUM_IPIN-1:0]   ipin_out,
    output logic                  cfg_valid,
    output logic                  cfg_err
);

    localparam int             SEL_W     = cb_sel_w(MUX_SIZE);
    localparam int             CFG_BITS  = cb_cfg_bits(NUM_IPIN, MUX_SIZE);
    localparam int             MUX_PAD   = 2 ** SEL_W;
    localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W+1)'(MUX_SIZE);

    logic [CFG_BITS-1:0] active;

    assign chany_bottom_out = chany_top_in;
    assign chany_top_out    = chany_bottom_in;

    cb_cfg_chain #(
        .NUM_IPIN (NUM_IPIN),
        .MUX_SIZE (MUX_SIZE),
        .SEL_W    (SEL_W),
        .CFG_BITS (CFG_BITS)
    ) u_cfg_chain (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .ccff_en      (ccff_en),
        .ccff_head    (ccff_head),
        .cfg_commit   (cfg_commit),
        .ccff_tail    (ccff_tail),
        .active       (active),
        .cfg_valid    (cfg_valid),
        .cfg_err      (cfg_err)
    );

    // Even mux inputs take the bottom track, odd ones the top track of the same index;
    // inputs past MUX_SIZE are tied low so any select value indexes safely.
    for (genvar i = 0; i < NUM_IPIN; i++) begin : g_mux
        logic [MUX_PAD-1:0] mux_in;
        logic [SEL_W-1:0]   sel;
        logic               sel_ok;

        for (genvar j = 0; j < MUX_PAD; j++) begin : g_in
            if (j >= MUX_SIZE) begin : g_pad
                assign mux_in[j] = 1'b0;
            end else if (j % 2 == 0) begin : g_bottom
                assign mux_in[j] = chany_bottom_in[(i*IPIN_STRIDE + j/2) % CHAN_WIDTH];
            end else begin : g_top
                assign mux_in[j] = chany_top_in[(i*IPIN_STRIDE + j/2) % CHAN_WIDTH];
            end
        end

        assign sel         = active[i*SEL_W +: SEL_W];
        assign sel_ok      = ({1'b0, sel} < SEL_LIMIT);
        assign ipin_out[i] = cfg_valid & sel_ok & mux_in[sel];
    end

endmodule

// File: tb/tb_cby_param_cfg.sv
// Directed bench for cby_param_cfg: two cascaded blocks checked every cycle
// against a bit-history model, plus hand-computed literal expectations.
module tb_cby_param_cfg;

    logic        prog_clk;
    logic        prog_reset_n;
    logic [10:0] bot_in;
    logic [10:0] top_in;
    logic        en;
    logic        head;
    logic        commit;

    logic [10:0] bo0, to0, bo1, to1;
    logic        tail0, tail1;
    logic [1:0]  ipin0, ipin1;
    logic        valid0, valid1, err0, err1;

    int n_cmp  = 0;
    int n_fail = 0;
    bit run_checks = 0;

    cby_param_cfg dut0 (
        .prog_clk         (prog_clk),
        .prog_reset_n     (prog_reset_n),
        .chany_bottom_in  (bot_in),
        .chany_top_in     (top_in),
        .chany_bottom_out (bo0),
        .chany_top_out    (to0),
        .ccff_en          (en),
        .ccff_head        (head),
        .ccff_tail        (tail0),
        .cfg_commit       (commit),
        .ipin_out         (ipin0),
        .cfg_valid        (valid0),
        .cfg_err          (err0)
    );

    cby_param_cfg dut1 (
        .prog_clk         (prog_clk),
        .prog_reset_n     (prog_reset_n),
        .chany_bottom_in  (bot_in),
        .chany_top_in     (top_in),
        .chany_bottom_out (bo1),
        .chany_top_out    (to1),
        .ccff_en          (en),
        .ccff_head        (tail0),
        .ccff_tail        (tail1),
        .cfg_commit       (commit),
        .ipin_out         (ipin1),
        .cfg_valid        (valid1),
        .cfg_err          (err1)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // Model: the ordered history of bits shifted in; instance 1 sees the bits 8 positions older.
    bit hist[$];
    int nshift;
    int m_sel[2][2];
    bit m_valid[2];
    bit m_err[2];

    function automatic bit chain_bit(int inst, int k);
        int idx;
        idx = hist.size() - 1 - inst*8 - k;
        return (idx >= 0) ? hist[idx] : 1'b0;
    endfunction

    function automatic int chain_sel(int inst, int i);
        int v;
        v = 0;
        for (int b = 0; b < 4; b++) v = v + (int'(chain_bit(inst, i*4 + b)) << b);
        return v;
    endfunction

    function automatic bit exp_ipin(int inst, int i);
        int s;
        int t;
        s = m_sel[inst][i];
        if (!m_valid[inst] || s >= 10) return 1'b0;
        t = (i + s/2) % 11;
        return (s % 2 == 1) ? top_in[t] : bot_in[t];
    endfunction

    task automatic model_reset();
        hist.delete();
        nshift = 0;
        for (int n = 0; n < 2; n++) begin
            m_valid[n] = 0;
            m_err[n]   = 0;
            m_sel[n][0] = 0;
            m_sel[n][1] = 0;
        end
    endtask

    task automatic model_edge(bit e, bit h, bit c);
        if (e) begin
            hist.push_back(h);
            if (hist.size() > 16) void'(hist.pop_front());
            nshift++;
        end else if (c) begin
            for (int n = 0; n < 2; n++) begin
                if (nshift == 8) begin
                    m_sel[n][0] = chain_sel(n, 0);
                    m_sel[n][1] = chain_sel(n, 1);
                    m_valid[n]  = 1;
                    if (m_sel[n][0] >= 10 || m_sel[n][1] >= 10) m_err[n] = 1;
                end else begin
                    m_err[n] = 1;
                end
            end
            nshift = 0;
        end
    endtask

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge prog_clk) begin
        if (run_checks) begin
            check_output("top_out",     32'(to0),   32'(bot_in));
            check_output("bottom_out",  32'(bo0),   32'(top_in));
            check_output("top_out1",    32'(to1),   32'(bot_in));
            check_output("bottom_out1", 32'(bo1),   32'(top_in));
            check_output("ipin0_m",     32'(ipin0), 32'({exp_ipin(0, 1), exp_ipin(0, 0)}));
            check_output("ipin1_m",     32'(ipin1), 32'({exp_ipin(1, 1), exp_ipin(1, 0)}));
            check_output("tail0_m",     32'(tail0), 32'(chain_bit(0, 7)));
            check_output("tail1_m",     32'(tail1), 32'(chain_bit(1, 7)));
            check_output("valid0_m",    32'(valid0), 32'(m_valid[0]));
            check_output("valid1_m",    32'(valid1), 32'(m_valid[1]));
            check_output("err0_m",      32'(err0),  32'(m_err[0]));
            check_output("err1_m",      32'(err1),  32'(m_err[1]));
        end
    end

    task automatic apply_stimulus(bit e, bit h, bit c);
        en = e;
        head = h;
        commit = c;
        @(posedge prog_clk);
        model_edge(e, h, c);
        #1;
        en = 0;
        head = 0;
        commit = 0;
    endtask

    task automatic shift_bits(logic [7:0] value, int n);
        for (int k = n - 1; k >= 0; k--) apply_stimulus(1'b1, value[k], 1'b0);
    endtask

    task automatic do_commit();
        apply_stimulus(1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        #2;
        prog_reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge prog_clk);
        #3;
        prog_reset_n = 1'b1;
        @(posedge prog_clk);
        #1;
    endtask

    initial begin
        logic [7:0] cfg;
        prog_reset_n = 1'b0;
        en = 0;
        head = 0;
        commit = 0;
        bot_in = 11'h5A5;
        top_in = 11'h2AA;
        model_reset();
        #1;
        run_checks = 1;

        // 1: reset state and pass-through, including while reset is held
        check_output("rst_top_out", 32'(to0), 32'h5A5);
        check_output("rst_bottom_out", 32'(bo0), 32'h2AA);
        repeat (2) @(posedge prog_clk);
        #3;
        prog_reset_n = 1'b1;
        @(posedge prog_clk);
        #1;
        check_output("t1_ipin", 32'(ipin0), 32'h0);
        check_output("t1_valid", 32'(valid0), 32'h0);
        check_output("t1_err", 32'(err0), 32'h0);

        // 2: mux1 sel=3 -> top[2]=0, mux0 sel=4 -> bottom[2]=1
        shift_bits(8'b0011_0100, 8);
        check_output("t2_pre_commit_ipin", 32'(ipin0), 32'h0);
        do_commit();
        check_output("t2_valid", 32'(valid0), 32'h1);
        check_output("t2_err", 32'(err0), 32'h0);
        check_output("t2_ipin", 32'(ipin0), 32'h1);
        bot_in = 11'h000;
        top_in = 11'h7FF;
        #1;
        check_output("t2_ipin_swap", 32'(ipin0), 32'h2);

        // 3: short load is flagged and discarded, then a full load still applies
        shift_bits(8'h7F, 7);
        do_commit();
        check_output("t3_err", 32'(err0), 32'h1);
        check_output("t3_valid", 32'(valid0), 32'h1);
        check_output("t3_ipin_kept", 32'(ipin0), 32'h2);
        bot_in = 11'h002;
        top_in = 11'h010;
        shift_bits(8'b0000_1001, 8);
        do_commit();
        check_output("t3_ipin_new", 32'(ipin0), 32'h3);
        check_output("t3_err_sticky", 32'(err0), 32'h1);

        // 4: mux0 sel=12 is out of range, mux1 sel=5 -> top[3]
        bot_in = 11'h7FF;
        top_in = 11'h008;
        shift_bits(8'b0101_1100, 8);
        do_commit();
        check_output("t4_ipin", 32'(ipin0), 32'h2);
        check_output("t4_err", 32'(err0), 32'h1);

        // 5: cascade; second block ends up with the first 8 bits shifted
        do_reset();
        bot_in = 11'h020;
        top_in = 11'h001;
        shift_bits(8'b1000_0001, 8);
        do_commit();
        shift_bits(8'b0001_0110, 8);
        check_output("t5_tail1_first_bit", 32'(tail1), 32'h1);
        do_commit();
        check_output("t5_valid1", 32'(valid1), 32'h1);
        check_output("t5_ipin1", 32'(ipin1), 32'h3);
        check_output("t5_ipin0", 32'(ipin0), 32'h0);
        check_output("t5_err0", 32'(err0), 32'h0);
        check_output("t5_err1", 32'(err1), 32'h0);

        // 6: reset after 5 shifted bits clears everything at once
        shift_bits(8'h1F, 5);
        check_output("t6_tail0_before", 32'(tail0), 32'h1);
        check_output("t6_ipin1_before", 32'(ipin1), 32'h3);
        #2;
        prog_reset_n = 1'b0;
        model_reset();
        #1;
        check_output("t6_ipin1_rst", 32'(ipin1), 32'h0);
        check_output("t6_tail0_rst", 32'(tail0), 32'h0);
        check_output("t6_tail1_rst", 32'(tail1), 32'h0);
        check_output("t6_valid0_rst", 32'(valid0), 32'h0);
        repeat (2) @(posedge prog_clk);
        #3;
        prog_reset_n = 1'b1;
        @(posedge prog_clk);
        #1;
        bot_in = 11'h5A5;
        top_in = 11'h2AA;
        cfg = 8'b0011_0100;
        for (int k = 7; k >= 0; k--) apply_stimulus(1'b1, cfg[k], (k == 4));
        check_output("t6_shift_commit_err", 32'(err0), 32'h0);
        check_output("t6_shift_commit_valid", 32'(valid0), 32'h0);
        do_commit();
        check_output("t6_valid", 32'(valid0), 32'h1);
        check_output("t6_err", 32'(err0), 32'h0);
        check_output("t6_ipin", 32'(ipin0), 32'h1);

        @(posedge prog_clk);
        @(negedge prog_clk);
        #1;
        run_checks = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
